// File: rtl/gated_delay_pipe.sv
// Per-channel NAND(a,b) gated by a registered gate bit, delayed through DEPTH stages,
// with valid tracking, hold/flush control, occupancy and saturating per-channel hit counters.
module gated_delay_pipe #(
  parameter int NCH   = 2,
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                   I1470,
  input  logic                   I1477,
  input  logic [NCH*WIDTH-1:0]   in_a,
  input  logic [NCH*WIDTH-1:0]   in_b,
  input  logic [NCH*WIDTH-1:0]   gate_in,
  input  logic                   in_valid,
  input  logic                   hold,
  input  logic                   flush,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic                   out_valid,
  output logic [OCC_W-1:0]       occupancy,
  output logic [NCH*CNT_W-1:0]   hit_cnt
);

  localparam int DW = NCH * WIDTH;

  logic [DW-1:0]    gate_q;
  logic [DW-1:0]    stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [OCC_W-1:0] occ_q;
  logic [DW-1:0]    d0;

  assign d0 = ~(in_a & in_b) & gate_q;

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      gate_q      <= '0;
      stage_valid <= '0;
      occ_q       <= '0;
      for (int i = 0; i < DEPTH; i++) stage_data[i] <= '0;
    end else if (flush) begin
      // flush wins over hold and drops the sample offered this cycle
      gate_q      <= '0;
      stage_valid <= '0;
      occ_q       <= '0;
      for (int i = 0; i < DEPTH; i++) stage_data[i] <= '0;
    end else if (!hold) begin
      gate_q         <= gate_in;
      stage_data[0]  <= d0;
      stage_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_data[i]  <= stage_data[i-1];
        stage_valid[i] <= stage_valid[i-1];
      end
      occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(stage_valid[DEPTH-1]);
    end
  end

  assign out_data  = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];
  assign occupancy = occ_q;

  for (genvar c = 0; c < NCH; c++) begin : g_hit
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    // counts the sample currently presented, i.e. the one about to shift out
    assign hit = !hold && out_valid && (|out_data[c*WIDTH +: WIDTH]);

    always_ff @(posedge I1470 or negedge I1477) begin
      if (!I1477) begin
        cnt_q <= '0;
      end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign hit_cnt[c*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_gated_delay_pipe.sv
// Randomized bench for gated_delay_pipe: an age-based reference model drives a
// scoreboard queue that a negedge monitor checks against the DUT outputs.
module tb_gated_delay_pipe;

  localparam int NCH   = 2;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int DW    = NCH * WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     in_a = '0, in_b = '0, gate_in = '0;
  logic              in_valid = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [OCC_W-1:0]  occupancy;
  logic [NCH*CNT_W-1:0] hit_cnt;

  gated_delay_pipe #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .I1470(clk), .I1477(rst_n), .in_a(in_a), .in_b(in_b), .gate_in(gate_in),
    .in_valid(in_valid), .hold(hold), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .occupancy(occupancy), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            age;   // accepting edges since entry; visible at output when age == DEPTH
  } ent_t;

  ent_t          m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] g_m = '0;
  int            cnt_m[NCH];
  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*CNT_W-1:0] exp_hits();
    logic [NCH*CNT_W-1:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++) e[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
    return e;
  endfunction

  function automatic bit model_vis();
    return (m_q.size() > 0) && (m_q[0].age == DEPTH);
  endfunction

  task automatic model_clear(input bit counters);
    m_q.delete();
    exp_q.delete();
    g_m = '0;
    if (counters) for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
  endtask

  // Applies the inputs sampled at this rising edge to the reference model.
  task automatic model_edge();
    bit            vis;
    logic [DW-1:0] d;
    vis = model_vis();
    if (!hold && vis)
      for (int c = 0; c < NCH; c++)
        if (m_q[0].data[c*WIDTH +: WIDTH] != '0 && cnt_m[c] < CMAX) cnt_m[c]++;
    if (flush) begin
      model_clear(0);
    end else if (!hold) begin
      if (vis) void'(m_q.pop_front());
      foreach (m_q[i]) m_q[i].age++;
      if (in_valid) begin
        d = ~(in_a & in_b) & g_m;
        m_q.push_back('{data: d, age: 1});
        exp_q.push_back(d);
      end
      g_m = gate_in;
    end
  endtask

  // Waits for an edge, folds it into the model, then drives the next inputs.
  task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] g,
                      input logic v, input logic h, input logic f);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    in_a = a; in_b = b; gate_in = g; in_valid = v; hold = h; flush = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called just after a step; asserts reset mid-cycle and checks outputs clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_clear(1);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_hit_cnt",   64'(hit_cnt),   64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(model_vis()));
      chk("occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("hit_cnt",   64'(hit_cnt),   64'(exp_hits()));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_data), 64'hDEAD);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q[0]));
          if (!hold) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] seen;
    bit            got;
    for (int c = 0; c < NCH; c++) cnt_m[c] = 0;

    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_out_data",  64'(out_data),  64'd0);
    chk("init_occupancy", 64'(occupancy), 64'd0);
    chk("init_hit_cnt",   64'(hit_cnt),   64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1;

    // Basic path: gate all ones, a=C b=A -> 7 per channel
    step('0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'hCC, 8'hAA, 8'hFF, 1'b1, 1'b0, 1'b0);
    got = 0; seen = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      step('0, '0, '0, 1'b0, 1'b0, 1'b0);
      if (out_valid) begin got = 1; seen = out_data; end
    end
    chk("basic_seen", 64'(got), 64'd1);
    chk("basic_data", 64'(seen), 64'h77);
    idle(DEPTH + 1);

    // Gate zero: output zero, counters must not move
    step(8'hCC, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'hCC, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
    got = 0; seen = 8'hFF;
    for (int i = 0; i < 10 && !got; i++) begin
      step('0, '0, '0, 1'b0, 1'b0, 1'b0);
      if (out_valid) begin got = 1; seen = out_data; end
    end
    chk("gate0_seen", 64'(got), 64'd1);
    chk("gate0_data", 64'(seen), 64'h00);
    idle(DEPTH + 1);

    // Hold for 3 cycles with samples in flight
    step('0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h12, 8'h34, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(8'h56, 8'h78, 8'hFF, 1'b1, 1'b0, 1'b0);
    step('0, '0, 8'hFF, 1'b0, 1'b1, 1'b0);
    step('0, '0, 8'hFF, 1'b1, 1'b1, 1'b0);
    step('0, '0, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle(DEPTH + 2);

    // Flush together with hold and a valid input
    step('0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h0F, 8'hF0, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    idle(DEPTH + 2);

    // Reset with samples in flight, then saturation from a clean slate
    step('0, '0, 8'hFF, 1'b1, 1'b0, 1'b0);
    step('0, '0, 8'hFF, 1'b1, 1'b0, 1'b0);
    step('0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    async_reset();
    step('0, '0, 8'h0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CMAX + 3; i++) step('0, '0, 8'h0F, 1'b1, 1'b0, 1'b0);
    idle(DEPTH + 3);
    chk("sat_hit_cnt", 64'(hit_cnt), 64'(CMAX));

    // Occupancy ramp: 10 consecutive valids then idle
    async_reset();
    step('0, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i < 10) step($urandom, $urandom, 8'hFF, 1'b1, 1'b0, 1'b0);
      else        step('0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("occ_ramp", 64'(occupancy),
          64'((i <= 10) ? ((i < DEPTH) ? i : DEPTH)
                        : ((DEPTH - (i - 10) > 0) ? DEPTH - (i - 10) : 0)));
    end

    // Random traffic with holds, flushes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom, $urandom, $urandom | $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 399) == 0) async_reset();
    end
    idle(DEPTH + 4);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gated_delay_pipe.md
# gated_delay_pipe

Parametrised successor to the team's fixed two-stage gated delay subcircuit. Each of NCH channels forms stage-0 data as NAND(a, b) AND a registered gate bit, then delays it through DEPTH register stages, extended from 1 to WIDTH bits per channel. New relative to the fixed version: valid tracking, hold (stall), synchronous flush, an occupancy count and a per-channel saturating hit counter. The block sits in the trojan-detection subcircuit library as the configurable replacement for hand-instantiated gated delay chains.

## Interface
- NCH, 2, number of independent channels (≥1)
- WIDTH, 1, data bits per channel (≥1)
- DEPTH, 2, pipeline register stages after the gating logic (≥1)
- CNT_W, 8, width of each per-channel hit counter (≥2)
- OCC_W, $clog2(DEPTH+1), width of occupancy output
- I1470  input  1  clock; all state updates on rising edge
- I1477  input  1  reset, asynchronous, active-low; clears all state
- in_a  input  NCH*WIDTH  operand a, channel c at bits [c*WIDTH +: WIDTH]
- in_b  input  NCH*WIDTH  operand b, same packing
- gate_in  input  NCH*WIDTH  gate source, registered before use
- in_valid  input  1  a/b sample valid this cycle
- hold  input  1  freeze all registers (except counters' saturation logic, which also freezes)
- flush  input  1  synchronous clear of pipeline, valids and gate registers
- out_data  output  NCH*WIDTH  last pipeline stage data
- out_valid  output  1  out_data holds an accepted sample
- occupancy  output  OCC_W  number of valid stages in flight, 0..DEPTH
- hit_cnt  output  NCH*CNT_W  per-channel count of valid non-zero outputs, saturating

## Operation
- Gate register g[c]: loads gate_in[c] every cycle when hold=0; frozen when hold=1.
- Stage-0 data: d0[c] = ~(in_a[c] & in_b[c]) & g[c], bitwise, WIDTH bits.
- Stage accept: when hold=0, stage 1 loads d0 and v1 = in_valid; stage k (k>1) loads stage k-1 data and valid. Data loads regardless of valid; only valid qualifies.
- out_data/out_valid = stage DEPTH data/valid.
- occupancy = population count of v1..vDEPTH, kept as a register updated incrementally: +in_valid entering, -valid leaving, net each shifted cycle; unchanged under hold.
- hit_cnt[c]: increments by 1 in a cycle where hold=0, out_valid=1 and out_data channel c ≠ 0; saturates at 2^CNT_W−1, never wraps. Counts the output presented before the shift.
- flush=1: next edge clears all stage data and valid to 0, g to 0, occupancy to 0; hit counters are NOT cleared. flush overrides hold and in_valid (input sample in the flush cycle is dropped).
- Reset (I1477=0): immediately clears every register, including hit counters, regardless of clock; mid-operation reset discards in-flight samples. First accept possible on first rising edge after I1477 returns high.

## Timing
- Reset values: out_data=0, out_valid=0, occupancy=0, hit_cnt=0, g=0.
- a/b to out_data latency: DEPTH cycles (sample presented at edge n appears after edge n+DEPTH with no hold).
- gate_in to effect on out_data: DEPTH+1 cycles; gate_in at cycle n gates a/b presented at cycle n+1.
- Each hold cycle adds one cycle of latency to every in-flight sample; outputs stable throughout hold.
- Back-to-back samples sustain one per cycle; no bubbles inserted.
- occupancy reaches DEPTH after DEPTH consecutive valid inputs and stays at DEPTH while in_valid=1 continuously.
- hit_cnt updates one edge after the qualifying output is visible.

## Test plan
- Reset: drive I1477=0 mid-stream with occupancy=2 (DEPTH=2) -> all outputs 0 immediately, asynchronously; first valid after release exits 2 cycles later.
- Basic path (NCH=2, WIDTH=4, DEPTH=2): gate_in=4'hF at cycle 0, then a=4'hC, b=4'hA, in_valid=1 at cycle 1 -> out_data ch=4'h7, out_valid=1 after edge 3; gate_in=0 case -> 4'h0, and hit_cnt unchanged for that sample.
- Hold: hold=1 for 3 cycles with 2 samples in flight -> out_data/out_valid/occupancy frozen, samples emerge in order 3 cycles late, none lost or duplicated.
- Flush vs hold: flush=1, hold=1, in_valid=1 same cycle -> next edge out_valid=0, occupancy=0, hit_cnt retained, the flush-cycle sample never appears.
- Saturation (CNT_W=2): 5 consecutive valid non-zero outputs on channel 0 -> hit_cnt ch0 = 3 and stays 3; channel 1 all-zero outputs -> 0.
- Throughput/occupancy (DEPTH=4): 10 consecutive valid inputs then idle -> occupancy 1,2,3,4,4,…,4,3,2,1,0; outputs in input order, one per cycle.
